hazard_stall_ctrl: RTL

//  Pipeline interlock controller for the 5-stage core. Decides each cycle whether the D-stage

---
 rtl/hazard_stall_ctrl_if.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// master = pipeline (drives operand/producer info), slave = controller.
interface hazard_stall_ctrl_if;
   logic [4:0]  rs_d;
   logic [4:0]  rt_d;
   logic [1:0]  tuse_rs_d;
   logic [1:0]  tuse_rt_d;
   logic [4:0]  a3_e;
   logic [1:0]  tnew_e;
   logic [4:0]  a3_m;
   logic [1:0]  tnew_m;
   logic        md_start_e;
   logic        md_div_e;
   logic        md_use_d;
   logic        stall;
   logic        md_busy;
   logic        md_done;
   logic [15:0] stall_cnt;

   modport master (
      output rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m,
             md_start_e, md_div_e, md_use_d,
      input  stall, md_busy, md_done, stall_cnt
   );

   modport slave (
      input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m,
             md_start_e, md_div_e, md_use_d,
      output stall, md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: stalls D when an operand is still pending, sequences the
// HI/LO mult/div busy counter, and counts stalled cycles (saturating).
module hazard_stall_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input logic            clk,
   input logic            reset_n,
   hazard_stall_ctrl_if.slave hz
);

   if (MULT_LAT < 1 || MULT_LAT > 15) begin : g_bad_mult_lat
      $error("hazard_stall_ctrl: MULT_LAT must lie in 1..15");
   end
   if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
      $error("hazard_stall_ctrl: DIV_LAT must lie in 1..15");
   end

   localparam logic [3:0] MULT_CNT = MULT_LAT[3:0];
   localparam logic [3:0] DIV_CNT  = DIV_LAT[3:0];

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t   state, state_nxt;
   logic [3:0]  md_cnt, md_cnt_nxt;
   logic [15:0] stall_cnt_q;
   logic        stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m, stall_md;
   logic        md_busy;

   // Register index 0 is never interlocked, so a3=0 ("no write") never matches.
   always_comb begin
      stall_rs_e = (hz.rs_d != '0) && (hz.rs_d == hz.a3_e) && (hz.tuse_rs_d < hz.tnew_e);
      stall_rs_m = (hz.rs_d != '0) && (hz.rs_d == hz.a3_m) && (hz.tuse_rs_d < hz.tnew_m);
      stall_rt_e = (hz.rt_d != '0) && (hz.rt_d == hz.a3_e) && (hz.tuse_rt_d < hz.tnew_e);
      stall_rt_m = (hz.rt_d != '0) && (hz.rt_d == hz.a3_m) && (hz.tuse_rt_d < hz.tnew_m);
   end

   assign md_busy  = hz.md_start_e | (md_cnt != '0);
   assign stall_md = hz.md_use_d & md_busy;

   assign hz.stall     = stall_rs_e | stall_rs_m | stall_rt_e | stall_rt_m | stall_md;
   assign hz.md_busy   = md_busy;
   assign hz.md_done   = (md_cnt == 4'd1);
   assign hz.stall_cnt = stall_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // A start seen while BUSY is ignored: the counter is never reloaded mid-operation.
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      unique case (state)
         IDLE: begin
            if (hz.md_start_e) begin
               md_cnt_nxt = hz.md_div_e ? DIV_CNT : MULT_CNT;
               state_nxt  = BUSY;
            end
         end
         BUSY: begin
            md_cnt_nxt = md_cnt - 4'd1;
            if (md_cnt == 4'd1) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            md_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (hz.stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

endmodule
